dsp_rr_scheduler: RTL
=====================

Name: dsp_rr_scheduler

Overview:
- Shares one DSP pre-add/multiply/post-add pipeline (P = (D±B)*A ± C, OPERATION fixed at build) among NUM_REQ requesters.
- Round-robin arbitration, one issue per cycle, registered operand drive to the DSP.
- Re-times C to match the DSP's internal C-vs-A skew.
- Tags each issue with its requester ID and returns the DSP's P output to the right requester on a response strobe.
- Sits between requester agents and a single DSP instance at the same level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width (clog2(NUM_REQ), min 1).
- A_W, 18, A/B/D operand width.
- C_W, 48, C operand and result width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- hold  in  1  when 1, no new grant this cycle.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot grant; handshake completes on valid&ready at the clock edge.
- req_a  in  NUM_REQ*A_W  flattened A operands; requester i at [i*A_W +: A_W].
- req_b  in  NUM_REQ*A_W  flattened B operands.
- req_d  in  NUM_REQ*A_W  flattened D operands.
- req_c  in  NUM_REQ*C_W  flattened C operands.
- dsp_a, dsp_b, dsp_d  out  A_W  registered operands to DSP.
- dsp_c  out  C_W  delayed C to DSP.
- dsp_p  in  C_W  DSP result.
- rsp_valid  out  1  result strobe.
- rsp_id  out  ID_W  requester owning the result.
- rsp_data  out  C_W  equals dsp_p (combinational pass-through).
- busy  out  1  any issue in flight.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low. While rst_n=0:
  - rr pointer = 0.
  - dsp_a/b/d/c = 0.
  - tag valid pipe = 0, tag IDs = 0.
  - rsp_valid = 0, rsp_id = 0, busy = 0.
  - req_ready = 0.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, wrapping modulo NUM_REQ. First set bit gets req_ready.
  - All req_ready = 0 if hold=1, if no request, or during reset.
  - At most one bit of req_ready is set.
- Pointer update: on a granted edge, ptr <= (granted_id+1) mod NUM_REQ. Otherwise ptr holds.
- Issue at edge k (handshake):
  - dsp_a/b/d <= granted operands.
  - c_dly0 <= granted C.
  - tag stage0 <= {1, granted_id}.
- No grant at edge k: dsp_a/b/d <= 0, c_dly0 <= 0, tag stage0 valid <= 0.
  - Zeroing is required so idle DSP cycles produce deterministic results.
- C alignment:
  - c_dly0 -> c_dly1 -> c_dly2 each edge; dsp_c = c_dly2.
  - The DSP samples A at edge k+1 and must sample the matching C at edge k+3.
- Tag pipeline:
  - 4 stages, shifts every edge.
  - rsp_valid = stage3.valid; rsp_id = stage3.id.
  - Stage3 is valid during the cycle after edge k+4, i.e. exactly when dsp_p holds the result.
- Latency: fixed, 4 edges from handshake to rsp_valid.
- Throughput: 1 result per cycle; back-to-back grants allowed, including to the same requester if it is the only one requesting.
- No response backpressure: the requester must accept rsp_valid the cycle it is asserted.
- busy = OR of the valid bits of tag stages 0..3.
- Reset mid-operation: all in-flight tags are dropped and no rsp_valid appears. The DSP shares rst_n, so its pipeline also clears.
- hold asserted with issues in flight: in-flight results still drain on schedule.
- Arithmetic: performed in the DSP. This block performs no math; it only routes operands and results.

Decomposition:
- Package dsp_sched_pkg:
  - DSP_LAT = 4 (issue -> P).
  - C_SKEW = 2 (extra C delay).
  - Widths A_W/C_W.
  - tag struct {logic vld; logic [ID_W-1:0] id}.
- Sub-module rr_arbiter (NUM_REQ): req, hold, ptr -> one-hot grant and encoded id; it also owns the pointer register.
- The C delay line and tag pipe stay in the top level.

Test Plan:
- Single request, ADD build: requester 2 with A=2, B=3, D=5, C=10 -> req_ready[2] high the same cycle; rsp_valid 4 cycles after handshake with rsp_id=2, rsp_data=26; busy high for exactly those 4 cycles.
- SUBTRACT build: A=4, B=1, D=7, C=5 -> rsp_data=19.
- All 4 requesters valid continuously, each with distinct A=i+1, B=0, D=1, C=0 -> grants 0,1,2,3,0,... one per cycle; responses in the same order, data 1,2,3,4,...
- Round-robin fairness: requesters 1 and 3 always valid, ptr=0 after reset -> grants 1,3,1,3; requester 3 is never starved.
- hold=1 for 3 cycles while two issues are in flight -> no req_ready during hold; both responses still arrive at +4; the idle slots produce no rsp_valid.
- rst_n pulsed low two cycles after an issue -> rsp_valid, busy and dsp_* go to 0 immediately; no stale response after reset release; the next issue after release returns its correct result.

Source files
------------

// File: rtl/dsp_sched_pkg.sv
// Shared widths, latencies and the issue-tag payload for the DSP round-robin scheduler.
package dsp_sched_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned ID_W_DEF    = 2;
    localparam int unsigned A_W_DEF     = 18;
    localparam int unsigned C_W_DEF     = 48;

    // Issue-to-P latency of the DSP and the extra C delay it expects relative to A.
    localparam int unsigned DSP_LAT     = 4;
    localparam int unsigned C_SKEW      = 2;

    // Tag ID is sized for the largest supported requester count (8).
    localparam int unsigned TAG_ID_W    = 3;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
        return (id + 1 == n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/dsp_rr_scheduler_arb.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer advances past each winner.
module rr_arbiter
    import dsp_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned ID_W    = ID_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_id_o,
    output logic               gnt_vld_o
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W-1:0] idx;

    // First requester at or after the pointer wins; reset and hold suppress all grants.
    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_vld_o = 1'b0;
        idx       = '0;
        ptr_d     = ptr_q;
        if (rst_n && !hold_i) begin
            for (int unsigned off = 0; off < NUM_REQ; off++) begin
                idx = ID_W'((32'(ptr_q) + off) % NUM_REQ);
                if (!gnt_vld_o && req_i[idx]) begin
                    gnt_vld_o  = 1'b1;
                    gnt_o[idx] = 1'b1;
                    gnt_id_o   = idx;
                end
            end
        end
        if (gnt_vld_o) begin
            ptr_d = ID_W'(rr_next(32'(gnt_id_o), NUM_REQ));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dsp_rr_scheduler.sv
// Shares one DSP pre-add/multiply/post-add pipe among requesters: arbitrates, registers operands,
// re-times C to the DSP's internal skew and tags each issue so P returns to its owner.
module dsp_rr_scheduler
    import dsp_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned ID_W    = ID_W_DEF,
    parameter int unsigned A_W     = A_W_DEF,
    parameter int unsigned C_W     = C_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hold_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*A_W-1:0] req_a_i,
    input  logic [NUM_REQ*A_W-1:0] req_b_i,
    input  logic [NUM_REQ*A_W-1:0] req_d_i,
    input  logic [NUM_REQ*C_W-1:0] req_c_i,
    output logic [A_W-1:0]         dsp_a_o,
    output logic [A_W-1:0]         dsp_b_o,
    output logic [A_W-1:0]         dsp_d_o,
    output logic [C_W-1:0]         dsp_c_o,
    input  logic [C_W-1:0]         dsp_p_i,
    output logic                   rsp_valid_o,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [C_W-1:0]         rsp_data_o,
    output logic                   busy_o
);

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_vld;

    logic [A_W-1:0] dsp_a_q, dsp_a_d;
    logic [A_W-1:0] dsp_b_q, dsp_b_d;
    logic [A_W-1:0] dsp_d_q, dsp_d_d;
    logic [C_W-1:0] c_dly_q [C_SKEW+1];
    logic [C_W-1:0] c_dly_d [C_SKEW+1];
    tag_t           tag_q   [DSP_LAT];
    tag_t           tag_d   [DSP_LAT];
    logic           rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic           busy_q, busy_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold_i    (hold_i),
        .req_i     (req_valid_i),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .gnt_vld_o (gnt_vld)
    );

    assign req_ready_o = gnt;

    // Idle slots drive zero operands so the DSP output stays deterministic between issues.
    always_comb begin
        dsp_a_d    = '0;
        dsp_b_d    = '0;
        dsp_d_d    = '0;
        c_dly_d[0] = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                dsp_a_d    = req_a_i[i*A_W +: A_W];
                dsp_b_d    = req_b_i[i*A_W +: A_W];
                dsp_d_d    = req_d_i[i*A_W +: A_W];
                c_dly_d[0] = req_c_i[i*C_W +: C_W];
            end
        end
        for (int unsigned j = 1; j <= C_SKEW; j++) begin
            c_dly_d[j] = c_dly_q[j-1];
        end
    end

    // Tag pipe tracks each issue until the DSP presents its P; the response is registered off the last stage.
    always_comb begin
        tag_d[0].vld = gnt_vld;
        tag_d[0].id  = TAG_ID_W'(gnt_id);
        for (int unsigned s = 1; s < DSP_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        busy_d = 1'b0;
        for (int unsigned s = 0; s < DSP_LAT; s++) begin
            busy_d = busy_d | tag_d[s].vld;
        end
        rsp_valid_d = tag_q[DSP_LAT-1].vld;
        rsp_id_d    = ID_W'(tag_q[DSP_LAT-1].id);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsp_a_q     <= '0;
            dsp_b_q     <= '0;
            dsp_d_q     <= '0;
            for (int unsigned j = 0; j <= C_SKEW; j++) begin
                c_dly_q[j] <= '0;
            end
            for (int unsigned s = 0; s < DSP_LAT; s++) begin
                tag_q[s] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            dsp_a_q     <= dsp_a_d;
            dsp_b_q     <= dsp_b_d;
            dsp_d_q     <= dsp_d_d;
            for (int unsigned j = 0; j <= C_SKEW; j++) begin
                c_dly_q[j] <= c_dly_d[j];
            end
            for (int unsigned s = 0; s < DSP_LAT; s++) begin
                tag_q[s] <= tag_d[s];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            busy_q      <= busy_d;
        end
    end

    assign dsp_a_o     = dsp_a_q;
    assign dsp_b_o     = dsp_b_q;
    assign dsp_d_o     = dsp_d_q;
    assign dsp_c_o     = c_dly_q[C_SKEW];
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = dsp_p_i;
    assign busy_o      = busy_q;

endmodule
